// File: rtl/intr_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_CAUSE = 2'd2;
    localparam logic [1:0] ADDR_EOI   = 2'd3;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-index-wins priority encoder over 8 request lines.
module prio_enc8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller: pending/mask registers, fixed
// priority (index 0 highest), single-level REQ/SERVICE handshake with EOI.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | nothing requested; waits for an eligible pending source
// ST_REQ     | intr asserted; waits for inta (or drops if nothing eligible)
// ST_SERVICE | cur_id being serviced; intr held low until EOI
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NSRC-1:0] irq,
    input  logic            inta,
    output logic            intr,
    output logic [2:0]      cur_id,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    state_e          state_q, state_d;
    logic [NSRC-1:0] irq_q, irq_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            intr_q, intr_d;
    logic [2:0]      cur_id_q, cur_id_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] elig;
    logic [7:0]      elig8;
    logic [2:0]      winner;
    logic            elig_any;
    logic            wr_mask, wr_pend, wr_eoi;
    logic            accept;
    logic            unused_wdata;

    assign rise     = irq & ~irq_q;
    assign elig     = pend_q & ~mask_q;
    assign wr_mask  = we && (addr == ADDR_MASK);
    assign wr_pend  = we && (addr == ADDR_PEND);
    assign wr_eoi   = we && (addr == ADDR_EOI);
    assign accept   = (state_q == ST_REQ) && inta && elig_any;

    // Upper write-data bits have no destination when NSRC < 32.
    assign unused_wdata = ^wdata[31:NSRC];

    // Widen the eligible vector to the encoder's fixed 8-bit input.
    always_comb begin
        elig8 = '0;
        elig8[NSRC-1:0] = elig;
    end

    prio_enc8 u_prio (
        .req (elig8),
        .idx (winner),
        .any (elig_any)
    );

    // State register and all datapath flops; reset masks every source.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '1;
            intr_q   <= 1'b0;
            cur_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            intr_q   <= intr_d;
            cur_id_q <= cur_id_d;
        end
    end

    // Next-state logic; inta only matters in REQ with something eligible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (elig_any) state_d = ST_REQ;
            ST_REQ: begin
                if (inta && elig_any) state_d = ST_SERVICE;
                else if (!elig_any)   state_d = ST_IDLE;
            end
            ST_SERVICE: if (wr_eoi) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and register-update logic; a new rise always beats a clear.
    always_comb begin
        irq_d    = irq;
        mask_d   = wr_mask ? wdata[NSRC-1:0] : mask_q;
        pend_d   = pend_q;
        if (wr_pend) pend_d = pend_d & ~wdata[NSRC-1:0];
        if (accept)  pend_d = pend_d & ~(NSRC'(1) << winner);
        pend_d   = pend_d | rise;
        intr_d   = (state_d == ST_REQ);
        cur_id_d = accept ? winner : cur_id_q;
    end

    // Combinational register read-back, zero-extended.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_MASK:  rdata = 32'(mask_q);
            ADDR_PEND:  rdata = 32'(pend_q);
            ADDR_CAUSE: rdata = {(state_q == ST_SERVICE), 28'd0, cur_id_q};
            default:    rdata = 32'd0;
        endcase
    end

    assign intr   = intr_q;
    assign cur_id = cur_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with an expectation queue.
module tb_intr_ctrl;
    import intr_ctrl_pkg::*;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            clrn;
    logic [NSRC-1:0] irq;
    logic            inta;
    logic            intr;
    logic [2:0]      cur_id;
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    intr_ctrl #(.NSRC(NSRC)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .irq    (irq),
        .inta   (inta),
        .intr   (intr),
        .cur_id (cur_id),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", e.tag, obs, e.v);
        end
    endtask

    task automatic chk_reg(input logic [1:0] a);
        addr = a;
        #1;
        chk(rdata);
    endtask

    task automatic chk_intr();
        chk({31'd0, intr});
    endtask

    task automatic chk_id();
        chk({29'd0, cur_id});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    initial begin
        clrn  = 1'b0;
        irq   = '0;
        inta  = 1'b0;
        we    = 1'b0;
        addr  = ADDR_MASK;
        wdata = 32'd0;
        #12;

        // reset values
        push("rst_intr", 0);     chk_intr();
        push("rst_id", 0);       chk_id();
        push("rst_mask", 32'hFF); chk_reg(ADDR_MASK);
        push("rst_pend", 0);     chk_reg(ADDR_PEND);
        tick();
        clrn = 1'b1;
        tick();

        // single source: irq[3]
        wr(ADDR_MASK, 32'h0);
        push("s3_pend_k", 32'h08); push("s3_intr_k", 0);
        irq = 8'h08;
        tick();
        chk_reg(ADDR_PEND); chk_intr();
        irq = 8'h00;
        push("s3_intr_k1", 1);
        tick();
        chk_intr();
        push("s3_id", 3); push("s3_pend_ack", 0); push("s3_intr_ack", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_id(); chk_reg(ADDR_PEND); chk_intr();
        push("s3_cause_svc", 32'h8000_0003); chk_reg(ADDR_CAUSE);
        wr(ADDR_EOI, 32'hFFFF_FFFF);
        push("s3_cause_eoi", 32'h0000_0003); chk_reg(ADDR_CAUSE);

        // simultaneous irq[5] and irq[2]
        irq = 8'h24;
        tick();
        irq = 8'h00;
        push("p_intr", 1);
        tick();
        chk_intr();
        push("p_id2", 2); push("p_pend", 32'h20); push("p_intr_svc", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_id(); chk_reg(ADDR_PEND); chk_intr();
        push("p_intr_eoi", 0);
        wr(ADDR_EOI, 32'h0);
        chk_intr();
        push("p_intr_reassert", 1);
        tick();
        chk_intr();
        push("p_id5", 5); push("p_pend_empty", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_id(); chk_reg(ADDR_PEND);
        wr(ADDR_EOI, 32'h0);

        // masking
        wr(ADDR_MASK, 32'hFF);
        push("m_pend", 32'h02);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        chk_reg(ADDR_PEND);
        push("m_intr_masked", 0);
        tick();
        chk_intr();
        push("m_intr_wr_edge", 0);
        wr(ADDR_MASK, 32'hFD);
        chk_intr();
        push("m_intr_unmask", 1);
        tick();
        chk_intr();
        push("m_intr_remask_edge", 1);
        wr(ADDR_MASK, 32'hFF);
        chk_intr();
        push("m_intr_dropped", 0);
        tick();
        chk_intr();
        push("m_inta_ignored", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_intr();
        push("m_pend_w1c", 0);
        wr(ADDR_PEND, 32'h02);
        chk_reg(ADDR_PEND);

        // service of irq[4], new rises during service
        wr(ADDR_MASK, 32'h0);
        irq = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        push("v_id4", 4); chk_id();
        push("v_pend0", 32'h01); push("v_intr_svc", 0);
        irq = 8'h01;
        tick();
        chk_reg(ADDR_PEND); chk_intr();
        irq = 8'h00;
        tick();
        push("v_set_wins", 32'h01);
        irq = 8'h01;
        wr(ADDR_PEND, 32'h01);
        chk_reg(ADDR_PEND);
        push("v_w1c_clear", 0);
        wr(ADDR_PEND, 32'h01);
        chk_reg(ADDR_PEND);
        push("v_cause", 32'h8000_0004); chk_reg(ADDR_CAUSE);
        push("v_inta_id", 4); push("v_inta_intr", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_id(); chk_intr();
        irq = 8'h00;
        tick();
        irq = 8'h01;
        tick();

        // asynchronous reset in SERVICE with irq[0] held high
        #2;
        clrn = 1'b0;
        #1;
        push("r_intr", 0);     chk_intr();
        push("r_id", 0);       chk_id();
        push("r_mask", 32'hFF); chk_reg(ADDR_MASK);
        push("r_pend", 0);     chk_reg(ADDR_PEND);
        push("r_cause", 0);    chk_reg(ADDR_CAUSE);
        #1;
        clrn = 1'b1;
        push("r_rise_after", 32'h01);
        tick();
        chk_reg(ADDR_PEND);
        push("r_inta_intr", 0); push("r_inta_id", 0);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk_intr(); chk_id();
        wr(ADDR_EOI, 32'h0);
        push("r_eoi_cause", 0); chk_reg(ADDR_CAUSE);
        push("r_eoi_intr", 0);  chk_intr();
        push("r_held_no_rise", 0);
        wr(ADDR_PEND, 32'hFF);
        tick();
        chk_reg(ADDR_PEND);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: NSRC, 8, number of interrupt sources; legal range 2..8.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 clrn  input  1  reset, asynchronous and active-low.
REQ-004 irq  input  NSRC  level sources, synchronous to clk; a rising edge requests service.
REQ-005 inta  input  1  interrupt acknowledge from the CPU, sampled on the clk edge.
REQ-006 intr  output  1  registered interrupt request to the CPU.
REQ-007 cur_id  output  3  index of the source in service; valid while in SERVICE.
REQ-008 we  input  1  register write strobe.
REQ-009 addr  input  2  register select: 0 MASK, 1 PEND, 2 CAUSE, 3 EOI.
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  combinational read data for addr.

Function
REQ-012 An edge detector SHALL use one register of irq per source: rise[i] = irq[i] & ~irq_q[i].
REQ-013 pend[i] SHALL set on the edge where rise[i]=1, so it is visible after that edge.
REQ-014 Simultaneous set and clear on the same pend bit SHALL resolve to set.
REQ-015 elig = pend & ~mask; winner = lowest index set in elig (index 0 highest priority).
REQ-016 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-017 IDLE -> REQ on the edge where elig != 0; intr <= 1 on that same edge.
REQ-018 REQ -> SERVICE on an edge with inta=1 and elig != 0. On that edge:
- cur_id <= winner
- pend[winner] <= 0
- intr <= 0
REQ-019 REQ -> IDLE, with intr <= 0, on an edge with elig == 0 (for example after a mask write or W1C) and inta=0.
REQ-020 inta SHALL be ignored in IDLE and SERVICE, and in REQ when elig == 0.
REQ-021 In SERVICE, intr SHALL stay 0. New edges still set pend bits. No nesting.
REQ-022 SERVICE -> IDLE on an edge with we=1 and addr=3 (EOI); wdata is ignored. EOI outside SERVICE SHALL be ignored.
REQ-023 After EOI, a still-eligible pend SHALL re-assert intr exactly one edge later, via IDLE -> REQ.
REQ-024 MASK write (addr 0) SHALL load mask <= wdata[NSRC-1:0]; the new mask takes effect on the following edge.
REQ-025 PEND write (addr 1) SHALL be write-1-to-clear: pend <= (pend & ~wdata) | rise.
REQ-026 A write to CAUSE (addr 2) SHALL have no effect.
REQ-027 rdata SHALL be zero-extended and selected by addr:
- addr 0: mask
- addr 1: pend
- addr 2: {in_service, 26'b0, 2'b0, cur_id}, with in_service in bit 31
- addr 3: 0
REQ-028 Latency: irq rise sampled at edge k gives intr=1 after edge k+1 if unmasked and state is IDLE at edge k+1.
REQ-029 Bits of mask, pend and irq above NSRC-1 SHALL read 0.

Reset
REQ-030 With clrn=0, immediately and regardless of clk:
- state = IDLE
- intr = 0
- cur_id = 0
- pend = 0
- irq_q = 0
- mask = all ones (all sources masked)
REQ-031 A reset while in REQ or SERVICE SHALL abandon the request with no residual pend. The first edge after release follows REQ-012 with irq_q=0, so an irq held high registers as a rise.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the register address constants (MASK, PEND, CAUSE, EOI).
REQ-033 The lowest-index priority encoder SHALL be one sub-module, prio_enc8 (8-bit input, 3-bit index, any flag). Unused inputs are tied to 0.

Verification
REQ-034 Reset release; write MASK=0x00; pulse irq[3] for 1 cycle -> pend=0x08 after edge k; intr=1 after edge k+1; inta=1 for one cycle -> cur_id=3, pend=0x00, intr=0.
REQ-035 irq[5] and irq[2] rise on the same edge -> intr=1; inta -> cur_id=2, pend=0x20. EOI -> intr=1 one edge later; inta -> cur_id=5.
REQ-036 MASK=0xFF; irq[1] rises -> pend=0x02, intr stays 0. Write MASK=0xFD -> intr=1 one edge after the write edge. Write MASK=0xFF while in REQ -> intr=0 and state IDLE.
REQ-037 In SERVICE (cur_id=4), irq[0] rises -> pend=0x01, intr stays 0. Write PEND with 0x01 on the same edge as an irq[0] rise -> pend bit stays 1. Read CAUSE -> 0x80000004.
REQ-038 Assert clrn=0 mid-SERVICE (asynchronously) -> intr=0, mask=0xFF, pend=0 immediately. inta and EOI after release -> no state change.
